// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// operand-forwarding select codes.
package hazard_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        MEM_WAIT = 3'd1,
        FLUSH    = 3'd2,
        HALTED   = 3'd3
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    // EX/MEM result is newer than MEM/WB, so it wins when both match.
    function automatic fwd_sel_t fwd_pick(input logic exmem_hit, input logic memwb_hit);
        if (exmem_hit) begin
            return FWD_EXMEM;
        end else if (memwb_hit) begin
            return FWD_MEMWB;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// Combinational EX-stage operand forwarding selects for the two ID/EX sources.
module forward_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              exmem_wen,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              memwb_wen,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [REG_AW-1:0] idex_rs,
    input  logic [REG_AW-1:0] idex_rt,
    output fwd_sel_t          fwd_a,
    output fwd_sel_t          fwd_b
);

    logic exmem_live;
    logic memwb_live;

    always_comb begin
        exmem_live = exmem_wen && (exmem_rd != '0);
        memwb_live = memwb_wen && (memwb_rd != '0);
        fwd_a = fwd_pick(exmem_live && (exmem_rd == idex_rs), memwb_live && (memwb_rd == idex_rs));
        fwd_b = fwd_pick(exmem_live && (exmem_rd == idex_rt), memwb_live && (memwb_rd == idex_rt));
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard/stall controller: load-use and RAW stalls, branch squash with
// pending flush, memory-wait freeze, sticky halt and a saturating stall counter.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter bit          FWD_EN   = 1'b1,
    parameter int unsigned STALL_CW = 16
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                ihit,
    input  logic                dhit,
    input  logic                exmem_dreq,
    input  logic                idex_dREN,
    input  logic                idex_wen,
    input  logic [REG_AW-1:0]   idex_rd,
    input  logic [REG_AW-1:0]   idex_rs,
    input  logic [REG_AW-1:0]   idex_rt,
    input  logic [REG_AW-1:0]   ifid_rs,
    input  logic [REG_AW-1:0]   ifid_rt,
    input  logic                ifid_uses_rt,
    input  logic                exmem_wen,
    input  logic [REG_AW-1:0]   exmem_rd,
    input  logic                memwb_wen,
    input  logic [REG_AW-1:0]   memwb_rd,
    input  logic                branch_taken,
    input  logic                memwb_halt,
    output logic                pc_enable,
    output logic                ifid_enable,
    output logic                idex_enable,
    output logic                exmem_enable,
    output logic                memwb_enable,
    output logic                ifid_flush,
    output logic                idex_flush,
    output logic                exmem_flush,
    output logic                memwb_flush,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic [2:0]          hz_state,
    output logic [STALL_CW-1:0] stall_cycles
);

    hz_state_t             state_q, state_d;
    logic                  pend_q, pend_d;
    logic [STALL_CW-1:0]   stall_q;
    fwd_sel_t              fu_a, fu_b;
    logic                  load_hz, raw_hz, ex_en;

    forward_unit #(
        .REG_AW (REG_AW)
    ) u_forward_unit (
        .exmem_wen (exmem_wen),
        .exmem_rd  (exmem_rd),
        .memwb_wen (memwb_wen),
        .memwb_rd  (memwb_rd),
        .idex_rs   (idex_rs),
        .idex_rt   (idex_rt),
        .fwd_a     (fu_a),
        .fwd_b     (fu_b)
    );

    function automatic logic src_hit(input logic [REG_AW-1:0] rd);
        return (rd != '0) && ((ifid_rs == rd) || (ifid_uses_rt && (ifid_rt == rd)));
    endfunction

    always_comb begin
        load_hz = idex_dREN && src_hit(idex_rd);
        raw_hz  = !FWD_EN && ((idex_wen && src_hit(idex_rd)) || (exmem_wen && src_hit(exmem_rd)));
        ex_en   = ihit || dhit;

        state_d      = state_q;
        pend_d       = pend_q;
        pc_enable    = 1'b0;
        ifid_enable  = 1'b0;
        idex_enable  = 1'b0;
        exmem_enable = 1'b0;
        memwb_enable = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;

        if (nRST) begin
            state_d = RUN;
            pend_d  = 1'b0;
        end else if (state_q != HALTED && memwb_halt) begin
            state_d = HALTED;
        end else begin
            unique case (state_q)
                RUN, MEM_WAIT: begin
                    if (state_q == MEM_WAIT && !dhit) begin
                        pend_d = pend_q || branch_taken;
                    end else if (exmem_dreq && !dhit) begin
                        state_d = MEM_WAIT;
                        pend_d  = pend_q || branch_taken;
                    end else if (branch_taken || pend_q) begin
                        state_d = RUN;
                        if (ihit) begin
                            pc_enable    = 1'b1;
                            ifid_enable  = 1'b1;
                            idex_enable  = 1'b1;
                            exmem_enable = 1'b1;
                            memwb_enable = 1'b1;
                            ifid_flush   = 1'b1;
                            idex_flush   = 1'b1;
                            pend_d       = 1'b0;
                        end else begin
                            // Redirect target is latched now; wait for the fetch in FLUSH.
                            state_d    = FLUSH;
                            pc_enable  = 1'b1;
                            ifid_flush = 1'b1;
                        end
                    end else if (load_hz || raw_hz) begin
                        state_d      = RUN;
                        idex_flush   = 1'b1;
                        idex_enable  = ex_en;
                        exmem_enable = ex_en;
                        memwb_enable = ex_en;
                    end else begin
                        state_d      = RUN;
                        pc_enable    = ihit;
                        ifid_enable  = ihit;
                        idex_enable  = ex_en;
                        exmem_enable = ex_en;
                        memwb_enable = ex_en;
                        ifid_flush   = dhit && !ihit;
                    end
                end
                FLUSH: begin
                    ifid_flush   = 1'b1;
                    idex_enable  = ex_en;
                    exmem_enable = ex_en;
                    memwb_enable = ex_en;
                    if (ihit) begin
                        idex_flush = 1'b1;
                        pend_d     = 1'b0;
                        state_d    = RUN;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (!pc_enable && state_q != HALTED && stall_q != '1) begin
                stall_q <= stall_q + STALL_CW'(1);
            end
        end
    end

    always_comb begin
        fwd_a = FWD_NONE;
        fwd_b = FWD_NONE;
        if (!nRST && FWD_EN) begin
            fwd_a = fu_a;
            fwd_b = fu_b;
        end
    end

    assign exmem_flush  = 1'b0;
    assign memwb_flush  = 1'b0;
    assign hz_state     = state_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: a forwarding instance and a no-forwarding
// instance with a narrow counter share one stimulus stream.
module tb_hazard_ctrl_unit;
    import hazard_pkg::*;

    logic       CLK = 1'b0;
    logic       nRST, ihit, dhit, exmem_dreq, idex_dREN, idex_wen, ifid_uses_rt;
    logic       exmem_wen, memwb_wen, branch_taken, memwb_halt;
    logic [4:0] idex_rd, idex_rs, idex_rt, ifid_rs, ifid_rt, exmem_rd, memwb_rd;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_fl, idex_fl, exmem_fl, memwb_fl;
    logic [1:0]  fa, fb;
    logic [2:0]  st;
    logic [15:0] stall;

    logic        n_pc_en, n_ifid_en, n_idex_en, n_exmem_en, n_memwb_en;
    logic        n_ifid_fl, n_idex_fl, n_exmem_fl, n_memwb_fl;
    logic [1:0]  n_fa, n_fb;
    logic [2:0]  n_st;
    logic [1:0]  n_stall;

    int n_cmp = 0;
    int n_err = 0;
    int exp_stall = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl_unit u_dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_dreq(exmem_dreq),
        .idex_dREN(idex_dREN), .idex_wen(idex_wen), .idex_rd(idex_rd), .idex_rs(idex_rs),
        .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .memwb_wen(memwb_wen),
        .memwb_rd(memwb_rd), .branch_taken(branch_taken), .memwb_halt(memwb_halt),
        .pc_enable(pc_en), .ifid_enable(ifid_en), .idex_enable(idex_en),
        .exmem_enable(exmem_en), .memwb_enable(memwb_en), .ifid_flush(ifid_fl),
        .idex_flush(idex_fl), .exmem_flush(exmem_fl), .memwb_flush(memwb_fl),
        .fwd_a(fa), .fwd_b(fb), .hz_state(st), .stall_cycles(stall)
    );

    hazard_ctrl_unit #(
        .FWD_EN   (1'b0),
        .STALL_CW (2)
    ) u_nofwd (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .exmem_dreq(exmem_dreq),
        .idex_dREN(idex_dREN), .idex_wen(idex_wen), .idex_rd(idex_rd), .idex_rs(idex_rs),
        .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_uses_rt(ifid_uses_rt),
        .exmem_wen(exmem_wen), .exmem_rd(exmem_rd), .memwb_wen(memwb_wen),
        .memwb_rd(memwb_rd), .branch_taken(branch_taken), .memwb_halt(memwb_halt),
        .pc_enable(n_pc_en), .ifid_enable(n_ifid_en), .idex_enable(n_idex_en),
        .exmem_enable(n_exmem_en), .memwb_enable(n_memwb_en), .ifid_flush(n_ifid_fl),
        .idex_flush(n_idex_fl), .exmem_flush(n_exmem_fl), .memwb_flush(n_memwb_fl),
        .fwd_a(n_fa), .fwd_b(n_fb), .hz_state(n_st), .stall_cycles(n_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        ihit = 1'b1; dhit = 1'b0; exmem_dreq = 1'b0; idex_dREN = 1'b0; idex_wen = 1'b0;
        ifid_uses_rt = 1'b0; exmem_wen = 1'b0; memwb_wen = 1'b0; branch_taken = 1'b0;
        memwb_halt = 1'b0; idex_rd = '0; idex_rs = '0; idex_rt = '0; ifid_rs = '0;
        ifid_rt = '0; exmem_rd = '0; memwb_rd = '0;
    endtask

    initial begin
        clear_inputs();
        nRST = 1'b1;
        tick();

        // Reset: outputs forced low even with a live forward match
        exmem_wen = 1'b1; exmem_rd = 5'd7; idex_rs = 5'd7;
        settle();
        chk("rst_pc_en", pc_en, 0);
        chk("rst_fwd_a", fa, 0);
        chk("rst_idex_en", idex_en, 0);
        tick();
        chk("rst_state", st, RUN);
        chk("rst_stall", stall, 0);
        clear_inputs();
        nRST = 1'b0;

        // 1: load-use on rt
        idex_dREN = 1'b1; idex_wen = 1'b1; idex_rd = 5'd3;
        ifid_rs = 5'd4; ifid_rt = 5'd3; ifid_uses_rt = 1'b1;
        settle();
        chk("lu_pc_en", pc_en, 0);
        chk("lu_ifid_en", ifid_en, 0);
        chk("lu_idex_fl", idex_fl, 1);
        chk("lu_idex_en", idex_en, 1);
        chk("lu_memwb_en", memwb_en, 1);
        tick(); exp_stall = 1;
        chk("lu_stall", stall, exp_stall);
        idex_dREN = 1'b0; idex_wen = 1'b0;
        settle();
        chk("lu_after_pc_en", pc_en, 1);
        chk("lu_after_idex_fl", idex_fl, 0);
        tick();
        chk("lu_after_stall", stall, exp_stall);
        idex_dREN = 1'b1; idex_rd = 5'd0; ifid_rs = 5'd0;
        settle();
        chk("lu_r0_pc_en", pc_en, 1);
        idex_rd = 5'd3; ifid_rs = 5'd4; ifid_rt = 5'd3; ifid_uses_rt = 1'b0;
        settle();
        chk("lu_no_rt_pc_en", pc_en, 1);
        clear_inputs();

        // 2: forwarding priority
        exmem_wen = 1'b1; exmem_rd = 5'd7; memwb_wen = 1'b1; memwb_rd = 5'd7;
        idex_rs = 5'd7; idex_rt = 5'd7;
        settle();
        chk("fwd_a_exmem", fa, FWD_EXMEM);
        chk("fwd_b_exmem", fb, FWD_EXMEM);
        chk("nofwd_fwd_a", n_fa, FWD_NONE);
        exmem_wen = 1'b0;
        settle();
        chk("fwd_a_memwb", fa, FWD_MEMWB);
        memwb_rd = 5'd0; idex_rs = 5'd0;
        settle();
        chk("fwd_a_r0", fa, FWD_NONE);
        clear_inputs();

        // 3: memory wait
        exmem_dreq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("mw_pc_en", pc_en, 0);
            chk("mw_memwb_en", memwb_en, 0);
            tick(); exp_stall++;
            chk("mw_state", st, MEM_WAIT);
        end
        chk("mw_stall", stall, exp_stall);
        dhit = 1'b1;
        settle();
        chk("mw_done_pc_en", pc_en, 1);
        chk("mw_done_memwb_en", memwb_en, 1);
        chk("mw_done_ifid_fl", ifid_fl, 0);
        tick();
        chk("mw_done_state", st, RUN);
        chk("mw_done_stall", stall, exp_stall);
        exmem_dreq = 1'b0; ihit = 1'b0;
        settle();
        chk("dcyc_ifid_fl", ifid_fl, 1);
        chk("dcyc_pc_en", pc_en, 0);
        chk("dcyc_idex_en", idex_en, 1);
        tick(); exp_stall++;
        dhit = 1'b0;

        // 4: branch with fetch miss
        branch_taken = 1'b1; ihit = 1'b0;
        settle();
        chk("br_pc_en", pc_en, 1);
        chk("br_ifid_fl", ifid_fl, 1);
        tick();
        chk("br_state1", st, FLUSH);
        chk("br_stall1", stall, exp_stall);
        settle();
        chk("fl_pc_en", pc_en, 0);
        chk("fl_ifid_fl", ifid_fl, 1);
        chk("fl_idex_fl", idex_fl, 0);
        tick(); exp_stall++;
        chk("br_state2", st, FLUSH);
        branch_taken = 1'b0; ihit = 1'b1;
        settle();
        chk("fl_hit_ifid_fl", ifid_fl, 1);
        chk("fl_hit_idex_fl", idex_fl, 1);
        chk("fl_hit_pc_en", pc_en, 0);
        tick(); exp_stall++;
        chk("fl_exit_state", st, RUN);
        chk("fl_exit_stall", stall, exp_stall);
        settle();
        chk("fl_pend_clr_ifid_fl", ifid_fl, 0);
        chk("fl_pend_clr_pc_en", pc_en, 1);

        // Branch seen during a memory wait is replayed from pend_flush
        exmem_dreq = 1'b1; branch_taken = 1'b1;
        settle();
        chk("pend_pc_en", pc_en, 0);
        tick(); exp_stall++;
        chk("pend_state", st, MEM_WAIT);
        branch_taken = 1'b0; dhit = 1'b1;
        settle();
        chk("pend_ifid_fl", ifid_fl, 1);
        chk("pend_idex_fl", idex_fl, 1);
        chk("pend_pc_en2", pc_en, 1);
        tick();
        exmem_dreq = 1'b0; dhit = 1'b0;
        settle();
        chk("pend_done_ifid_fl", ifid_fl, 0);
        chk("pend_done_idex_fl", idex_fl, 0);

        // 5: branch beats load-use
        branch_taken = 1'b1; idex_dREN = 1'b1; idex_wen = 1'b1; idex_rd = 5'd3; ifid_rs = 5'd3;
        settle();
        chk("brlu_pc_en", pc_en, 1);
        chk("brlu_ifid_fl", ifid_fl, 1);
        chk("brlu_idex_fl", idex_fl, 1);
        tick();
        chk("brlu_stall", stall, exp_stall);
        clear_inputs();

        // 7: no-forwarding RAW stalls
        idex_wen = 1'b1; idex_rd = 5'd2; ifid_rs = 5'd2;
        exmem_wen = 1'b1; exmem_rd = 5'd2; idex_rs = 5'd2; idex_rt = 5'd2;
        settle();
        chk("nf_pc_en", n_pc_en, 0);
        chk("nf_idex_fl", n_idex_fl, 1);
        chk("nf_fwd_a", n_fa, 0);
        chk("nf_fwd_b", n_fb, 0);
        chk("fw_pc_en", pc_en, 1);
        chk("fw_fwd_a", fa, FWD_EXMEM);
        tick();
        chk("nf_stall_sat", n_stall, 3);
        idex_wen = 1'b0;
        settle();
        chk("nf_exmem_pc_en", n_pc_en, 0);
        exmem_rd = 5'd0;
        settle();
        chk("nf_clear_pc_en", n_pc_en, 1);
        clear_inputs();

        // 6: sticky halt
        memwb_halt = 1'b1;
        settle();
        chk("halt_pc_en", pc_en, 0);
        chk("halt_memwb_en", memwb_en, 0);
        tick(); exp_stall++;
        chk("halt_state", st, HALTED);
        memwb_halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("halted_pc_en", pc_en, 0);
            chk("halted_ifid_fl", ifid_fl, 0);
            tick();
            chk("halted_state", st, HALTED);
            chk("halted_stall", stall, exp_stall);
        end
        nRST = 1'b1;
        tick();
        chk("halt_rst_state", st, RUN);
        chk("halt_rst_stall", stall, 0);
        nRST = 1'b0;
        settle();
        chk("post_rst_pc_en", pc_en, 1);
        chk("exmem_flush", exmem_fl, 0);
        chk("memwb_flush", memwb_fl, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
